// File: rtl/ah_pcam.sv
// ah_pcam: small fully-associative pointer CAM with lowest-free-slot allocation,
// registered lowest-index search, optional free-on-hit and explicit deallocation.
module ah_pcam #(
   parameter int unsigned DEPTH       = 20,
   parameter int unsigned DATA_W      = 128,
   parameter int unsigned KEY_W       = 68,
   parameter int unsigned FREE_ON_HIT = 1,
   localparam int unsigned IW         = $clog2(DEPTH),
   localparam int unsigned CW         = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_an,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic [IW-1:0]     wr_idx,
   input  logic              srch_valid,
   input  logic [KEY_W-1:0]  srch_key,
   output logic              rsp_valid,
   output logic              rsp_hit,
   output logic [IW-1:0]     rsp_idx,
   output logic [DATA_W-1:0] rsp_data,
   input  logic              free_valid,
   input  logic [IW-1:0]     free_idx,
   output logic [CW-1:0]     count,
   output logic              full,
   output logic              empty
);

   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [CW-1:0]     count_q, count_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_hit_q, rsp_hit_d;
   logic [IW-1:0]     rsp_idx_q, rsp_idx_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

   logic              free_found;
   logic [IW-1:0]     free_slot;
   logic              match_any;
   logic [IW-1:0]     match_idx;
   logic              wr_acc;
   logic [DEPTH-1:0]  clr_mask;
   logic [DEPTH-1:0]  set_mask;
   logic [CW-1:0]     clr_cnt;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign wr_ready = ~full;
   assign wr_idx   = free_slot;
   assign wr_acc   = wr_valid & ~full;

   assign count     = count_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_hit   = rsp_hit_q;
   assign rsp_idx   = rsp_idx_q;
   assign rsp_data  = rsp_data_q;

   // Lowest index whose valid bit is clear (0 when full).
   always_comb begin
      free_found = 1'b0;
      free_slot  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (!free_found && !valid_q[i]) begin
            free_found = 1'b1;
            free_slot  = IW'(i);
         end
      end
   end

   // Lowest valid entry whose key field equals the search key.
   always_comb begin
      match_any = 1'b0;
      match_idx = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (!match_any && valid_q[i] && (data_q[i][KEY_W-1:0] == srch_key)) begin
            match_any = 1'b1;
            match_idx = IW'(i);
         end
      end
   end

   // Next occupancy: clears are masked to currently-valid entries, so a hit-free and an
   // explicit free of the same entry merge into one bit and count drops by one.
   always_comb begin
      clr_mask = '0;
      if (srch_valid && match_any && (FREE_ON_HIT != 0))
         clr_mask[match_idx] = 1'b1;
      if (free_valid && (32'(free_idx) < DEPTH))
         clr_mask[free_idx] = 1'b1;
      clr_mask = clr_mask & valid_q;

      clr_cnt = '0;
      for (int unsigned i = 0; i < DEPTH; i++)
         clr_cnt = clr_cnt + CW'(clr_mask[i]);

      set_mask = '0;
      if (wr_acc)
         set_mask[free_slot] = 1'b1;

      valid_d = (valid_q & ~clr_mask) | set_mask;
      count_d = count_q + CW'(wr_acc) - clr_cnt;

      data_d = data_q;
      if (wr_acc)
         data_d[free_slot] = wr_data;
   end

   // Search response, zeroed whenever there is no hit.
   always_comb begin
      rsp_valid_d = srch_valid;
      rsp_hit_d   = srch_valid & match_any;
      rsp_idx_d   = rsp_hit_d ? match_idx : '0;
      rsp_data_d  = rsp_hit_d ? data_q[match_idx] : '0;
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         valid_q     <= '0;
         count_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_hit_q   <= 1'b0;
         rsp_idx_q   <= '0;
         rsp_data_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++)
            data_q[i] <= '0;
      end else begin
         valid_q     <= valid_d;
         count_q     <= count_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_hit_q   <= rsp_hit_d;
         rsp_idx_q   <= rsp_idx_d;
         rsp_data_q  <= rsp_data_d;
         data_q      <= data_d;
      end
   end

endmodule

// File: tb/tb_ah_pcam.sv
// tb_ah_pcam: two instances (free-on-hit and non-destructive) driven with shared
// stimulus and compared each cycle against an array-based reference model.
module tb_ah_pcam;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned DW    = 16;
   localparam int unsigned KW    = 8;

   logic          clk = 1'b0;
   logic          rst_an = 1'b0;
   logic          wr_valid = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          srch_valid = 1'b0;
   logic [KW-1:0] srch_key = '0;
   logic          free_valid = 1'b0;
   logic [1:0]    free_idx = '0;

   logic [1:0]         wr_ready_o;
   logic [1:0][1:0]    wr_idx_o;
   logic [1:0]         rsp_valid_o;
   logic [1:0]         rsp_hit_o;
   logic [1:0][1:0]    rsp_idx_o;
   logic [1:0][DW-1:0] rsp_data_o;
   logic [1:0][2:0]    count_o;
   logic [1:0]         full_o;
   logic [1:0]         empty_o;

   int checks = 0;
   int errors = 0;

   // reference model: index 0 = free-on-hit instance, 1 = non-destructive
   bit            m_valid [2][DEPTH];
   logic [DW-1:0] m_data  [2][DEPTH];
   bit            e_rv    [2];
   bit            e_hit   [2];
   int            e_idx   [2];
   logic [DW-1:0] e_data  [2];

   always #5 clk = ~clk;

   ah_pcam #(.DEPTH(DEPTH), .DATA_W(DW), .KEY_W(KW), .FREE_ON_HIT(1)) u_foh (
      .clk(clk), .rst_an(rst_an),
      .wr_valid(wr_valid), .wr_ready(wr_ready_o[0]), .wr_data(wr_data), .wr_idx(wr_idx_o[0]),
      .srch_valid(srch_valid), .srch_key(srch_key),
      .rsp_valid(rsp_valid_o[0]), .rsp_hit(rsp_hit_o[0]), .rsp_idx(rsp_idx_o[0]),
      .rsp_data(rsp_data_o[0]),
      .free_valid(free_valid), .free_idx(free_idx),
      .count(count_o[0]), .full(full_o[0]), .empty(empty_o[0])
   );

   ah_pcam #(.DEPTH(DEPTH), .DATA_W(DW), .KEY_W(KW), .FREE_ON_HIT(0)) u_keep (
      .clk(clk), .rst_an(rst_an),
      .wr_valid(wr_valid), .wr_ready(wr_ready_o[1]), .wr_data(wr_data), .wr_idx(wr_idx_o[1]),
      .srch_valid(srch_valid), .srch_key(srch_key),
      .rsp_valid(rsp_valid_o[1]), .rsp_hit(rsp_hit_o[1]), .rsp_idx(rsp_idx_o[1]),
      .rsp_data(rsp_data_o[1]),
      .free_valid(free_valid), .free_idx(free_idx),
      .count(count_o[1]), .full(full_o[1]), .empty(empty_o[1])
   );

   task automatic chk(input string tag, input int m, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, m, obs, exp);
      end
   endtask

   function automatic int m_count(input int m);
      int n = 0;
      for (int i = 0; i < DEPTH; i++) n += m_valid[m][i] ? 1 : 0;
      return n;
   endfunction

   function automatic int m_first_free(input int m);
      for (int i = 0; i < DEPTH; i++) if (!m_valid[m][i]) return i;
      return -1;
   endfunction

   task automatic m_reset();
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < DEPTH; i++) begin
            m_valid[m][i] = 1'b0;
            m_data[m][i]  = '0;
         end
         e_rv[m] = 1'b0; e_hit[m] = 1'b0; e_idx[m] = 0; e_data[m] = '0;
      end
   endtask

   task automatic idle();
      wr_valid = 1'b0; srch_valid = 1'b0; free_valid = 1'b0;
   endtask

   // One clock: check pre-edge combinational outputs, advance the model, check after the edge.
   task automatic step();
      int cnt, ff, hit;
      bit nv [DEPTH];
      #1;
      for (int m = 0; m < 2; m++) begin
         cnt = m_count(m);
         ff  = m_first_free(m);
         chk("count", m, 32'(count_o[m]), cnt);
         chk("full", m, 32'(full_o[m]), (cnt == DEPTH) ? 1 : 0);
         chk("empty", m, 32'(empty_o[m]), (cnt == 0) ? 1 : 0);
         chk("wr_ready", m, 32'(wr_ready_o[m]), (cnt < DEPTH) ? 1 : 0);
         chk("wr_idx", m, 32'(wr_idx_o[m]), (ff < 0) ? 0 : ff);
         hit = -1;
         if (srch_valid)
            for (int i = 0; i < DEPTH; i++)
               if (hit < 0 && m_valid[m][i] && m_data[m][i][KW-1:0] == srch_key) hit = i;
         e_rv[m]   = srch_valid;
         e_hit[m]  = (hit >= 0);
         e_idx[m]  = (hit >= 0) ? hit : 0;
         e_data[m] = (hit >= 0) ? m_data[m][hit] : '0;
         for (int i = 0; i < DEPTH; i++) nv[i] = m_valid[m][i];
         if (hit >= 0 && m == 0) nv[hit] = 1'b0;
         if (free_valid) nv[free_idx] = 1'b0;
         if (wr_valid && cnt < DEPTH) begin
            nv[ff] = 1'b1;
            m_data[m][ff] = wr_data;
         end
         for (int i = 0; i < DEPTH; i++) m_valid[m][i] = nv[i];
      end
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
         chk("rsp_valid", m, 32'(rsp_valid_o[m]), e_rv[m] ? 1 : 0);
         chk("rsp_hit", m, 32'(rsp_hit_o[m]), e_hit[m] ? 1 : 0);
         chk("rsp_idx", m, 32'(rsp_idx_o[m]), e_idx[m]);
         chk("rsp_data", m, 32'(rsp_data_o[m]), 32'(e_data[m]));
         chk("count_post", m, 32'(count_o[m]), m_count(m));
      end
      @(negedge clk);
   endtask

   task automatic do_write(input logic [DW-1:0] d);
      idle(); wr_valid = 1'b1; wr_data = d; step();
   endtask

   task automatic do_search(input logic [KW-1:0] k);
      idle(); srch_valid = 1'b1; srch_key = k; step();
   endtask

   task automatic do_free(input logic [1:0] i);
      idle(); free_valid = 1'b1; free_idx = i; step();
   endtask

   initial begin
      m_reset();
      repeat (2) @(negedge clk);
      rst_an = 1'b1;
      idle();
      step();   // reset state

      // fill, then a fifth write that must be dropped
      do_write(16'h1111); do_write(16'h2222); do_write(16'h3333); do_write(16'h4444);
      chk("full_after_fill", 0, 32'(full_o[0]), 1);
      do_write(16'h5555);

      // destructive search in instance 0; repeat misses there, still hits in instance 1
      do_search(8'h22);
      chk("hit_data_22", 0, 32'(rsp_data_o[0]), 32'h2222);
      chk("hit_idx_22", 0, 32'(rsp_idx_o[0]), 1);
      chk("count_after_hit", 0, 32'(count_o[0]), 3);
      do_search(8'h22);
      chk("rehit_22", 0, 32'(rsp_hit_o[0]), 0);
      chk("rehit_22", 1, 32'(rsp_hit_o[1]), 1);

      // refill, then free+write in one cycle on a full CAM
      do_write(16'h2222);
      idle(); free_valid = 1'b1; free_idx = 2'd2; wr_valid = 1'b1; wr_data = 16'h5555; step();
      chk("count_free_full", 0, 32'(count_o[0]), 3);
      do_write(16'h5555);
      chk("count_refill", 0, 32'(count_o[0]), 4);

      // empty it, then write/search collision
      for (int i = 0; i < DEPTH; i++) do_free(2'(i));
      chk("empty_after_free", 1, 32'(empty_o[1]), 1);
      idle(); wr_valid = 1'b1; wr_data = 16'h7777; srch_valid = 1'b1; srch_key = 8'h77; step();
      chk("same_cycle_miss", 0, 32'(rsp_hit_o[0]), 0);
      do_search(8'h77);
      chk("next_cycle_hit", 1, 32'(rsp_hit_o[1]), 1);

      // multiple matches resolve to lowest index
      for (int i = 0; i < DEPTH; i++) do_free(2'(i));
      do_write(16'h1155); do_write(16'h3300); do_write(16'h2255); do_free(2'd1);
      do_search(8'h55);
      chk("multi_idx", 1, 32'(rsp_idx_o[1]), 0);
      chk("multi_data", 1, 32'(rsp_data_o[1]), 32'h1155);
      chk("multi_count", 1, 32'(count_o[1]), 2);

      // explicit free and hit-free on the same entry
      idle(); srch_valid = 1'b1; srch_key = 8'h55; free_valid = 1'b1; free_idx = 2'd2; step();
      idle(); srch_valid = 1'b1; srch_key = 8'h55; free_valid = 1'b1; free_idx = 2'd0; step();

      // randomized traffic with colliding small keys
      for (int n = 0; n < 400; n++) begin
         wr_valid   = ($urandom_range(0, 99) < 45);
         wr_data    = DW'($urandom);
         wr_data[KW-1:0] = KW'($urandom_range(0, 5));
         srch_valid = ($urandom_range(0, 99) < 50);
         srch_key   = KW'($urandom_range(0, 6));
         free_valid = ($urandom_range(0, 99) < 25);
         free_idx   = 2'($urandom_range(0, 3));
         step();
      end

      // reset during an in-flight search with three entries held
      for (int i = 0; i < DEPTH; i++) do_free(2'(i));
      do_write(16'h0a01); do_write(16'h0b02); do_write(16'h0c03);
      do_search(8'h02);
      idle(); srch_valid = 1'b1; srch_key = 8'h01;
      #2 rst_an = 1'b0;
      #1;
      m_reset();
      for (int m = 0; m < 2; m++) begin
         chk("rst_count", m, 32'(count_o[m]), 0);
         chk("rst_rsp_valid", m, 32'(rsp_valid_o[m]), 0);
      end
      @(negedge clk);
      idle();
      rst_an = 1'b1;
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ah_pcam.md
AH_PCAM -- requirements
Module: ah_pcam

Interface
REQ-001 SHALL have parameter DEPTH, default 20: number of entries, legal 2..64.
REQ-002 SHALL have parameter DATA_W, default 128: stored entry width.
REQ-003 SHALL have parameter KEY_W, default 68: search key width, KEY_W <= DATA_W; the key of an entry is data[KEY_W-1:0].
REQ-004 SHALL have parameter FREE_ON_HIT, default 1: 1 = search hit deallocates the hit entry, 0 = search is non-destructive.
REQ-005 SHALL provide these ports (IW = $clog2(DEPTH), CW = $clog2(DEPTH+1)):
  clk  in  1  clock, all state on rising edge
  rst_an  in  1  reset, asynchronous, active-low
  wr_valid  in  1  write request
  wr_ready  out  1  free entry available
  wr_data  in  DATA_W  entry to store
  wr_idx  out  IW  index the current write will occupy
  srch_valid  in  1  search request
  srch_key  in  KEY_W  search key
  rsp_valid  out  1  search result valid, registered
  rsp_hit  out  1  search matched
  rsp_idx  out  IW  matched index
  rsp_data  out  DATA_W  matched entry data
  free_valid  in  1  explicit deallocate request
  free_idx  in  IW  entry to deallocate
  count  out  CW  occupied entries
  full  out  1  count == DEPTH
  empty  out  1  count == 0

Function
REQ-006 SHALL keep one valid bit and one DATA_W data register per entry.
REQ-007 SHALL drive wr_ready = ~full and wr_idx = lowest index whose valid bit is clear, combinationally from pre-edge state.
REQ-008 SHALL, on a rising edge with wr_valid & wr_ready, store wr_data at wr_idx and set its valid bit; wr_valid while full SHALL be ignored with no state change.
REQ-009 SHALL compare srch_key against the key of valid entries only; invalid entries never match.
REQ-010 SHALL register the search result one cycle after srch_valid: rsp_valid = 1 for exactly one cycle per accepted search; searches are accepted every cycle (no backpressure).
REQ-011 SHALL, on multiple matches, report the lowest matching index in rsp_idx and that entry's data in rsp_data.
REQ-012 SHALL, on no match, drive rsp_hit = 0, rsp_idx = 0, rsp_data = 0 with rsp_valid = 1.
REQ-013 SHALL hold rsp_hit, rsp_idx, rsp_data at 0 in any cycle where rsp_valid = 0.
REQ-014 SHALL, when FREE_ON_HIT = 1, clear the valid bit of the reported hit entry on the same edge that registers the result; data contents are retained.
REQ-015 SHALL, on free_valid, clear valid[free_idx]; freeing an already-invalid entry or free_idx >= DEPTH SHALL be ignored.
REQ-016 SHALL evaluate write, search and free against pre-edge state: a same-cycle write is not visible to a same-cycle search; an entry freed this cycle is not allocatable until the next cycle.
REQ-017 SHALL, when explicit free and hit-free target the same entry in one cycle, clear it once and decrement count by one.
REQ-018 SHALL update count on each edge as count + write_accepted - (number of distinct valid entries cleared), saturating never required since range is 0..DEPTH; full and empty SHALL be derived from registered count.
REQ-019 SHALL keep count equal to the population of the valid bits at all times.

Reset
REQ-020 SHALL, while rst_an = 0, asynchronously clear all valid bits, all data registers, count, rsp_valid, rsp_hit, rsp_idx, rsp_data.
REQ-021 SHALL present after reset: wr_ready = 1, wr_idx = 0, count = 0, empty = 1, full = 0.
REQ-022 SHALL abort any in-flight search on reset assertion; no rsp_valid pulse follows deassertion unless a new search is issued.

Verification
REQ-023 DEPTH=4, DATA_W=16, KEY_W=8: write 0x1111,0x2222,0x3333,0x4444 on consecutive cycles -> wr_idx 0,1,2,3; count 4; full = 1, wr_ready = 0; fifth write ignored.
REQ-024 FREE_ON_HIT=1, entries as above: search key 0x22 -> next cycle rsp_valid=1, rsp_hit=1, rsp_idx=1, rsp_data=0x2222; count 3; repeat search 0x22 -> rsp_hit=0, rsp_data=0.
REQ-025 Entries 0x1155 at idx 0 and 0x2255 at idx 2, FREE_ON_HIT=0: search 0x55 -> rsp_idx=0, rsp_data=0x1155; count unchanged.
REQ-026 Full CAM, same cycle free_idx=2 and write 0x5555 -> write ignored (wr_ready was 0), count 3; next cycle write 0x5555 -> wr_idx=2, count 4.
REQ-027 Same cycle write 0x7777 to idx 0 and search 0x77 on empty CAM -> rsp_hit=0; search 0x77 next cycle -> rsp_hit=1, rsp_idx=0.
REQ-028 Assert rst_an low with 3 entries and a search in flight -> count=0, rsp_valid=0 immediately; after release wr_idx=0, empty=1.
